// File: rtl/dm_responder_if.sv
// dm_responder_if: MEM-stage load/store request and response handshake bundle.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_byte, req_sext, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_byte, req_sext, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder, one access in flight, fixed latency,
// word/byte loads and stores with misalign/range error reporting.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  dm_responder_if.slave bus,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q, byte_q, sext_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [4:0] sh;
  logic [7:0] lane;
  logic [31:0] word, wr_word, rd_word;
  logic acc, err_c;
  assign idx     = addr_q[ADDR_W+1:2];
  assign sh      = {addr_q[1:0], 3'b000};
  assign word    = mem[idx];
  assign lane    = 8'(word >> sh);
  assign wr_word = byte_q ? (word & ~(32'hFF << sh)) | (32'(wdata_q[7:0]) << sh) : wdata_q;
  assign rd_word = byte_q ? {{24{sext_q & lane[7]}}, lane} : word;
  assign err_c   = (!byte_q && addr_q[1:0] != 2'b00) || (addr_q >> (ADDR_W + 2)) != 32'd0;
  assign acc     = state == WAIT && cnt == 4'd0;
  always_comb begin
    state_n = state == IDLE ? (bus.req_valid ? WAIT : IDLE) :
              state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
              (bus.resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      sext_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        byte_q  <= bus.req_byte;
        sext_q  <= bus.req_sext;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (acc) begin
        rdata_q <= (we_q || err_c) ? 32'd0 : rd_word;
        err_q   <= err_c;
      end else if (state == RESP && bus.resp_ready) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end
  // Array is not reset; an async reset drops state to IDLE, which cancels a pending write.
  always_ff @(posedge clk) begin
    if (acc && we_q && !err_c) mem[idx] <= wr_word;
  end
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = state != IDLE;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed and randomized checks of dm_responder against a byte-array model.
module tb_dm_responder;
  localparam int ADDR_W = 10, LATENCY = 2, BYTES = 4 << ADDR_W;
  logic clk = 0, rst_n = 0, busy;
  int passed = 0, total = 0;
  logic [7:0] m [BYTES];
  dm_responder_if bus();
  dm_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  always #5 clk = ~clk;
  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_byte = 0; bus.req_sext = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
  end
  task automatic ref_op(input logic we, byt, sext, input logic [31:0] a, wd, output logic [31:0] rd, output logic e);
    e = a >= 32'(BYTES) || (!byt && a[1:0] != 2'b00);
    rd = 0;
    if (!e) begin
      if (we && byt) m[a] = wd[7:0];
      else if (we) for (int i = 0; i < 4; i++) m[int'(a) + i] = wd[8*i +: 8];
      else if (byt) rd = {{24{sext & m[a][7]}}, m[a]};
      else rd = {m[int'(a) + 3], m[int'(a) + 2], m[int'(a) + 1], m[a]};
    end
  endtask
  task automatic send(input logic we, byt, sext, input logic [31:0] a, wd);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = we; bus.req_byte = byt; bus.req_sext = sext;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 0;
  endtask
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic take();
    @(negedge clk);
    bus.resp_ready = 1;
    @(posedge clk); #1;
    bus.resp_ready = 0;
  endtask
  task automatic run_op(input logic we, byt, sext, input logic [31:0] a, wd,
                        output logic [31:0] rd, output logic e, output logic [31:0] xrd, output logic xe, output int lat);
    send(we, byt, sext, a, wd);
    wait_resp(lat);
    rd = bus.resp_rdata; e = bus.resp_err;
    take();
    ref_op(we, byt, sext, a, wd, xrd, xe);
  endtask
  task automatic test_reset();
    int lat;
    #2;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b expected 1", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_idle got valid=%b busy=%b expected 0/0", bus.resp_valid, busy); else passed++;
    @(negedge clk); rst_n = 1;
    send(0, 0, 0, 32'h2, 0);
    wait_resp(lat);
    total++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) $display("FAIL reset_pre_resp got valid=%b err=%b expected 1/1", bus.resp_valid, bus.resp_err); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL async_reset got ready=%b valid=%b busy=%b expected 1/0/0", bus.req_ready, bus.resp_valid, busy); else passed++;
    total++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) $display("FAIL async_reset_data got %h/%b expected 0/0", bus.resp_rdata, bus.resp_err); else passed++;
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_word();
    logic [31:0] rd, xrd; logic e, xe; int lat;
    run_op(1, 0, 0, 32'h10, 32'hDEADBEEF, rd, e, xrd, xe, lat);
    total++; if (lat !== LATENCY) $display("FAIL store_latency got %0d expected %0d", lat, LATENCY); else passed++;
    total++; if (rd !== 32'h0 || e !== 1'b0) $display("FAIL store_resp got %h/%b expected 0/0", rd, e); else passed++;
    run_op(0, 0, 0, 32'h10, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL word_load got %h/%b expected deadbeef/0", rd, e); else passed++;
  endtask
  task automatic test_byte();
    logic [31:0] rd, xrd; logic e, xe; int lat;
    run_op(1, 0, 0, 32'h10, 32'h11223344, rd, e, xrd, xe, lat);
    run_op(1, 1, 0, 32'h13, 32'hABCDEF80, rd, e, xrd, xe, lat);
    run_op(0, 0, 0, 32'h10, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'h80223344) $display("FAIL byte_store_rmw got %h expected 80223344", rd); else passed++;
    run_op(0, 1, 1, 32'h13, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'hFFFFFF80) $display("FAIL byte_load_sext got %h expected ffffff80", rd); else passed++;
    run_op(0, 1, 0, 32'h13, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'h00000080) $display("FAIL byte_load_zext got %h expected 00000080", rd); else passed++;
    run_op(0, 1, 1, 32'h11, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'h00000033) $display("FAIL byte_load_lane1 got %h expected 00000033", rd); else passed++;
  endtask
  task automatic test_errors();
    logic [31:0] rd, xrd; logic e, xe; int lat;
    run_op(1, 0, 0, 32'h0, 32'h12345678, rd, e, xrd, xe, lat);
    run_op(0, 0, 0, 32'h6, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'h0 || e !== 1'b1) $display("FAIL misaligned_load got %h/%b expected 0/1", rd, e); else passed++;
    run_op(1, 0, 0, 32'(1 << (ADDR_W + 2)), 32'hFFFFFFFF, rd, e, xrd, xe, lat);
    total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL range_store got %h/%b expected 0/1", rd, e); else passed++;
    run_op(0, 0, 0, 32'h0, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'h12345678) $display("FAIL range_store_no_write got %h expected 12345678", rd); else passed++;
    run_op(1, 1, 0, 32'(BYTES - 1), 32'h5A, rd, e, xrd, xe, lat);
    run_op(0, 1, 0, 32'(BYTES - 1), 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'h5A || e !== 1'b0) $display("FAIL last_byte got %h/%b expected 5a/0", rd, e); else passed++;
    run_op(0, 1, 0, 32'h8000_0000, 0, rd, e, xrd, xe, lat);
    total++; if (e !== 1'b1) $display("FAIL high_addr_err got %b expected 1", e); else passed++;
  endtask
  task automatic test_backpressure();
    logic [31:0] rd, xrd, r0; logic e, xe, e0; int lat;
    run_op(1, 0, 0, 32'h20, 32'h55AA55AA, rd, e, xrd, xe, lat);
    send(0, 0, 0, 32'h20, 0);
    wait_resp(lat);
    r0 = bus.resp_rdata; e0 = bus.resp_err;
    total++; if (r0 !== 32'h55AA55AA || e0 !== 1'b0) $display("FAIL bp_first got %h/%b expected 55aa55aa/0", r0, e0); else passed++;
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_byte = 0; bus.req_addr = 32'h20; bus.req_wdata = 32'hBAD0BAD0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== r0 || bus.resp_err !== e0 || bus.req_ready !== 1'b0)
        $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h err=%b ready=%b expected 1/%h/%b/0", i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready, r0, e0);
      else passed++;
    end
    @(negedge clk); bus.req_valid = 0; bus.resp_ready = 1;
    @(posedge clk); #1; bus.resp_ready = 0;
    total++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.resp_rdata !== 32'h0)
      $display("FAIL bp_release got valid=%b ready=%b busy=%b rdata=%h expected 0/1/0/0", bus.resp_valid, bus.req_ready, busy, bus.resp_rdata);
    else passed++;
    run_op(0, 0, 0, 32'h20, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'h55AA55AA) $display("FAIL bp_ignored_req got %h expected 55aa55aa", rd); else passed++;
  endtask
  task automatic test_reset_wait();
    logic [31:0] rd, xrd; logic e, xe; int lat;
    run_op(1, 0, 0, 32'h20, 32'h0, rd, e, xrd, xe, lat);
    send(1, 0, 0, 32'h20, 32'hCAFEF00D);
    total++; if (busy !== 1'b1) $display("FAIL rw_in_wait got busy=%b expected 1", busy); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rw_reset got busy=%b expected 0", busy); else passed++;
    @(negedge clk); rst_n = 1;
    run_op(0, 0, 0, 32'h20, 0, rd, e, xrd, xe, lat);
    total++; if (rd !== 32'h0) $display("FAIL rw_store_dropped got %h expected 00000000", rd); else passed++;
  endtask
  task automatic test_random();
    logic [31:0] rd, xrd, a; logic e, xe, we, byt; int lat;
    for (int i = 0; i < 8; i++) run_op(1, 0, 0, 32'(4 * i), $urandom, rd, e, xrd, xe, lat);
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(ADDR_W + 2, 31));
      we = 1'($urandom); byt = 1'($urandom);
      run_op(we, byt, 1'($urandom), a, $urandom, rd, e, xrd, xe, lat);
      total++; if (rd !== xrd || e !== xe) $display("FAIL rand_%0d addr=%h we=%b byte=%b got %h/%b expected %h/%b", i, a, we, byt, rd, e, xrd, xe); else passed++;
      total++; if (lat !== LATENCY) $display("FAIL rand_lat_%0d got %0d expected %0d", i, lat, LATENCY); else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_word();
    test_byte();
    test_errors();
    test_backpressure();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
